// File: rtl/median_window_7.sv
// median_window_7: 7-deep per-frame sliding window that feeds the
// 7-input median sort network through a valid/ready handshake.
module median_window_7 #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   input  logic                  flush,
   output logic                  win_valid,
   input  logic                  win_ready,
   output logic                  win_last,
   output logic [DATA_WIDTH-1:0] data_0,
   output logic [DATA_WIDTH-1:0] data_1,
   output logic [DATA_WIDTH-1:0] data_2,
   output logic [DATA_WIDTH-1:0] data_3,
   output logic [DATA_WIDTH-1:0] data_4,
   output logic [DATA_WIDTH-1:0] data_5,
   output logic [DATA_WIDTH-1:0] data_6,
   output logic                  short_frame
);

   logic [DATA_WIDTH-1:0] r_tap [7];
   logic [2:0]            r_fill;
   logic                  r_win_valid;
   logic                  r_win_last;
   logic                  r_short;

   logic                  w_acc;
   logic                  w_hs;
   logic                  w_full;
   logic [2:0]            w_fill_n;

   // A pending window that is not being taken blocks the input.
   assign in_ready = ~(r_win_valid & ~win_ready) & ~flush;
   assign w_acc    = in_valid & in_ready;
   assign w_hs     = r_win_valid & win_ready;
   assign w_fill_n = (r_fill == 3'd7) ? 3'd7 : r_fill + 3'd1;
   assign w_full   = (w_fill_n == 3'd7);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 7; i++) begin
            r_tap[i] <= '0;
         end
      end else if (w_acc) begin
         for (int i = 0; i < 6; i++) begin
            r_tap[i] <= r_tap[i+1];
         end
         r_tap[6] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fill      <= 3'd0;
         r_win_valid <= 1'b0;
         r_win_last  <= 1'b0;
         r_short     <= 1'b0;
      end else if (flush) begin
         r_fill      <= 3'd0;
         r_win_valid <= 1'b0;
         r_win_last  <= 1'b0;
         r_short     <= 1'b0;
      end else if (w_acc) begin
         r_fill      <= in_last ? 3'd0 : w_fill_n;
         r_win_valid <= w_full;
         r_win_last  <= w_full & in_last;
         r_short     <= in_last & ~w_full;
      end else begin
         r_short <= 1'b0;
         if (w_hs) begin
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
         end
      end
   end

   assign win_valid   = r_win_valid;
   assign win_last    = r_win_last;
   assign short_frame = r_short;
   assign data_0      = r_tap[0];
   assign data_1      = r_tap[1];
   assign data_2      = r_tap[2];
   assign data_3      = r_tap[3];
   assign data_4      = r_tap[4];
   assign data_5      = r_tap[5];
   assign data_6      = r_tap[6];

endmodule

// File: tb/tb_median_window_7.sv
// tb_median_window_7: directed and random stimulus checked against a
// frame-queue reference model of the sliding window.
module tb_median_window_7;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        flush;
   logic        win_valid;
   logic        win_ready;
   logic        win_last;
   logic [31:0] data_0, data_1, data_2, data_3, data_4, data_5, data_6;
   logic        short_frame;

   median_window_7 #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .flush(flush),
      .win_valid(win_valid), .win_ready(win_ready), .win_last(win_last),
      .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
      .data_4(data_4), .data_5(data_5), .data_6(data_6),
      .short_frame(short_frame)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int nwin, nlast, nshort;

   // reference model: samples of the current frame, at most the newest 7
   logic [31:0] q[$];
   logic [31:0] m_win [7];
   bit          m_valid, m_last, m_short;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_valid = 0; m_last = 0; m_short = 0;
      for (int k = 0; k < 7; k++) m_win[k] = '0;
   endtask

   task automatic model_step(input bit acc, input logic [31:0] d,
                             input bit l, input bit wr, input bit fl);
      if (fl) begin
         q.delete();
         m_valid = 0; m_last = 0; m_short = 0;
      end else if (acc) begin
         q.push_back(d);
         if (q.size() > 7) void'(q.pop_front());
         m_short = 0;
         if (q.size() == 7) begin
            m_valid = 1;
            m_last  = l;
            for (int k = 0; k < 7; k++) m_win[k] = q[k];
         end else begin
            m_valid = 0;
            m_last  = 0;
         end
         if (l) begin
            m_short = (q.size() < 7);
            q.delete();
         end
      end else begin
         m_short = 0;
         if (m_valid && wr) begin
            m_valid = 0;
            m_last  = 0;
         end
      end
   endtask

   task automatic check_outputs();
      check("win_valid", win_valid, m_valid);
      check("win_last", win_last, m_last);
      check("short_frame", short_frame, m_short);
      if (short_frame) nshort++;
      if (m_valid) begin
         check("data_0", data_0, m_win[0]);
         check("data_1", data_1, m_win[1]);
         check("data_2", data_2, m_win[2]);
         check("data_3", data_3, m_win[3]);
         check("data_4", data_4, m_win[4]);
         check("data_5", data_5, m_win[5]);
         check("data_6", data_6, m_win[6]);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, win_valid, 0);
      check({tag, "_last"}, win_last, 0);
      check({tag, "_short"}, short_frame, 0);
      check({tag, "_d0"}, data_0, 0);
      check({tag, "_d1"}, data_1, 0);
      check({tag, "_d2"}, data_2, 0);
      check({tag, "_d3"}, data_3, 0);
      check({tag, "_d4"}, data_4, 0);
      check({tag, "_d5"}, data_5, 0);
      check({tag, "_d6"}, data_6, 0);
   endtask

   // one clock: drive at negedge, check ready, update model, check outputs
   task automatic step(input bit v, input logic [31:0] d, input bit l,
                       input bit wr, input bit fl, output bit acc);
      bit mr;
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      win_ready = wr;
      flush     = fl;
      #1;
      mr = !(m_valid && !wr) && !fl;
      check("in_ready", in_ready, mr);
      acc = v && mr;
      if (win_valid && wr) begin
         nwin++;
         if (win_last) nlast++;
      end
      @(posedge clk);
      model_step(acc, d, l, wr, fl);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic send(input logic [31:0] d, input bit l, input bit wr);
      bit a;
      a = 0;
      for (int i = 0; i < 50 && !a; i++) step(1, d, l, wr, 0, a);
      check("send_acc", a, 1);
   endtask

   task automatic idle(input int n, input bit wr);
      bit a;
      for (int i = 0; i < n; i++) step(0, 32'h0, 0, wr, 0, a);
   endtask

   task automatic clear_counts();
      nwin = 0; nlast = 0; nshort = 0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog time limit");
      $fatal(1);
   end

   initial begin
      bit a;
      rst_n = 0; in_valid = 0; in_data = 0; in_last = 0;
      flush = 0; win_ready = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      #1;
      check_zero("reset");
      check("reset_in_ready", in_ready, 1);
      @(negedge clk);

      // single frame 1..10
      clear_counts();
      for (int i = 1; i <= 10; i++) send(i, i == 10, 1);
      idle(2, 1);
      check("t1_windows", nwin, 4);
      check("t1_lasts", nlast, 1);

      // backpressure
      clear_counts();
      for (int i = 1; i <= 7; i++) send(i, 0, 1);
      check("bp_first_d0", data_0, 1);
      for (int i = 0; i < 5; i++) step(1, 8, 0, 0, 0, a);
      check("bp_hold_d6", data_6, 7);
      send(8, 0, 1);
      send(9, 1, 1);
      idle(2, 1);
      check("bp_windows", nwin, 3);

      // frame boundary
      clear_counts();
      for (int i = 1; i <= 8; i++) send(i, i == 8, 1);
      for (int i = 100; i <= 107; i++) send(i, i == 107, 1);
      idle(2, 1);
      check("fb_windows", nwin, 4);
      check("fb_lasts", nlast, 2);

      // short frame
      clear_counts();
      for (int i = 5; i <= 8; i++) send(i, i == 8, 1);
      idle(1, 1);
      for (int i = 1; i <= 7; i++) send(i, i == 7, 1);
      idle(2, 1);
      check("sf_pulses", nshort, 1);
      check("sf_windows", nwin, 1);

      // flush mid-fill
      clear_counts();
      for (int i = 1; i <= 5; i++) send(32'h50 + i, 0, 1);
      step(1, 32'hdead, 0, 1, 1, a);
      check("fl_no_acc", a, 0);
      for (int i = 1; i <= 7; i++) send(i, i == 7, 1);
      idle(2, 1);
      check("fl_windows", nwin, 1);

      // flush with a window pending
      for (int i = 1; i <= 7; i++) send(i, 0, 0);
      check("flp_pending", win_valid, 1);
      step(0, 0, 0, 0, 1, a);
      check("flp_cleared", win_valid, 0);
      idle(1, 1);

      // async reset while a window is pending
      for (int i = 1; i <= 7; i++) send(32'h70 + i, 0, 0);
      check("ar_pending", win_valid, 1);
      #2 rst_n = 0;
      #1;
      check_zero("async_rst");
      model_reset();
      @(negedge clk);
      rst_n = 1;
      #1;
      check("ar_in_ready", in_ready, 1);
      clear_counts();
      for (int i = 1; i <= 6; i++) send(i, 0, 1);
      check("ar_six", win_valid, 0);
      send(7, 1, 1);
      check("ar_seven", win_valid, 1);
      idle(2, 1);
      check("ar_windows", nwin, 1);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         step($urandom_range(0, 3) != 0, $urandom,
              $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 49) == 0, a);
      end
      idle(2, 1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
